// File: rtl/keypad_cmd_tx.sv
// Keypad command transmitter: debounces the 5-bit command vector and sends it as an
// 8N1 byte {3'b101, cmd} on every stable change, plus a periodic heartbeat resend.
module keypad_cmd_tx #(
  parameter int CLKS_PER_BIT   = 5208,
  parameter int STABLE_CYCLES  = 1000,
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  input  logic action,
  output logic tx,
  output logic busy
);

  localparam int BW = (CLKS_PER_BIT > 1)   ? $clog2(CLKS_PER_BIT)   : 1;
  localparam int SW = (STABLE_CYCLES > 1)  ? $clog2(STABLE_CYCLES)  : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX  = (REFRESH_CYCLES > 0) ? RW'(REFRESH_CYCLES - 1) : '0;
  localparam logic [2:0]    HEADER   = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [4:0]    cmd, cand, last_sent;
  logic [SW-1:0] stab_cnt;
  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stable, change_req, refresh_req, baud_done, frame_start;

  assign cmd = {action, right, left, down, up};

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cand     <= '0;
      stab_cnt <= '0;
    end else if (cmd != cand) begin
      cand     <= cmd;
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign stable      = (cmd == cand) && (stab_cnt == STAB_MAX);
  assign change_req  = stable && (cand != last_sent);
  assign refresh_req = (REFRESH_CYCLES != 0) && (ref_cnt == REF_MAX);
  assign baud_done   = (baud_cnt == BAUD_MAX);
  assign frame_start = (state_q == S_IDLE) && (change_req || refresh_req);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: each always_comb assigns a default before the case, so no path leaves an
  // output unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (change_req || refresh_req)     state_d = S_START;
      S_START: if (baud_done)                     state_d = S_DATA;
      S_DATA:  if (baud_done && bit_idx == 3'd7)  state_d = S_STOP;
      S_STOP:  if (baud_done)                     state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: tx   = 1'b0;
      S_DATA:  tx   = shift[bit_idx];
      S_STOP:  tx   = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      last_sent <= '0;
      ref_cnt   <= '0;
    end else begin
      // A change request wins over the heartbeat; the heartbeat repeats last_sent.
      if (frame_start) begin
        ref_cnt <= '0;
        if (change_req) begin
          shift     <= {HEADER, cand};
          last_sent <= cand;
        end else begin
          shift <= {HEADER, last_sent};
        end
      end else if (ref_cnt != REF_MAX) begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      if (state_d != state_q || state_q == S_IDLE || baud_done) baud_cnt <= '0;
      else                                                      baud_cnt <= baud_cnt + 1'b1;

      // Advances 8 times per frame, so it wraps back to 0 by the stop bit.
      if (state_q == S_DATA && baud_done) bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_cmd_tx.sv
// Scoreboard bench for keypad_cmd_tx: a run-length/timestamp reference model predicts
// each frame's byte and start edge; a line monitor decodes frames and compares.
module tb_keypad_cmd_tx;

  localparam int C     = 4;
  localparam int S     = 8;
  localparam int R     = 200;
  localparam int FRAME = 10 * C;

  typedef struct {
    int byte_v;
    int start;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] cmd = '0;
  logic [4:0] cmd2 = '0;
  logic       tx, busy, tx2, busy2;
  logic       rst_released = 1'b0;
  logic       d2_done = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  exp_t exp_q[$];
  int   m_prev, m_run, m_last_sent, m_last_start, m_busy_end;

  int frames_seen = 0;
  int mon_last_start = -1;
  int mon_prev_start = -1;
  int mon_last_byte = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_cmd_tx #(.CLKS_PER_BIT(C), .STABLE_CYCLES(S), .REFRESH_CYCLES(R)) u_dut (
    .clk(clk), .resetn(resetn),
    .up(cmd[0]), .down(cmd[1]), .left(cmd[2]), .right(cmd[3]), .action(cmd[4]),
    .tx(tx), .busy(busy)
  );

  keypad_cmd_tx #(.CLKS_PER_BIT(2), .STABLE_CYCLES(1), .REFRESH_CYCLES(0)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .up(cmd2[0]), .down(cmd2[1]), .left(cmd2[2]), .right(cmd2[3]), .action(cmd2[4]),
    .tx(tx2), .busy(busy2)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Reset behaves like a frame start at the release point with an implied sample of 0.
  task automatic model_reset();
    m_prev       = 0;
    m_run        = 1;
    m_last_sent  = 0;
    m_last_start = cyc;
    m_busy_end   = 0;
  endtask

  task automatic model_push(input int v, input int j);
    exp_q.push_back('{byte_v: 32'hA0 | v, start: j});
    m_last_start = j;
    m_busy_end   = j + FRAME + 1;
  endtask

  // Drive cmd for the next edge j; a vector seen on S+1 consecutive edges is stable.
  task automatic step(input logic [4:0] c);
    int j;
    cmd = c;
    j = cyc + 1;
    if (int'(c) == m_prev) m_run++;
    else begin
      m_run  = 1;
      m_prev = int'(c);
    end
    if (j >= m_busy_end) begin
      if (m_run >= S + 1 && int'(c) != m_last_sent) begin
        m_last_sent = int'(c);
        model_push(int'(c), j);
      end else if (R != 0 && j - m_last_start >= R) begin
        model_push(m_last_sent, j);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Line monitor for the main instance.
  int         mon_st, mon_exp, mon_busy_len, mon_aborted, mon_bi, mon_end_idle;
  logic [7:0] mon_b;
  logic       mon_stop;
  exp_t       mon_e;
  always begin
    @(negedge clk);
    if (resetn && (tx == 1'b0 || busy)) begin
      mon_st = cyc;
      frames_seen++;
      mon_prev_start = mon_last_start;
      mon_last_start = mon_st;
      mon_exp = -1;
      check("frame_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_exp = mon_e.byte_v;
        check("frame_start_cycle", mon_st, mon_e.start);
      end
      check("start_bit", int'(tx), 0);
      mon_busy_len = int'(busy);
      mon_aborted  = 0;
      mon_b        = '0;
      mon_stop     = 1'b0;
      mon_end_idle = 0;
      for (int off = 1; off <= FRAME && mon_aborted == 0; off++) begin
        @(negedge clk);
        if (!resetn) mon_aborted = 1;
        else if (off == FRAME) mon_end_idle = int'(!busy && tx);
        else begin
          mon_busy_len += int'(busy);
          if (off % C == C / 2) begin
            mon_bi = off / C;
            if (mon_bi >= 1 && mon_bi <= 8) mon_b[mon_bi-1] = tx;
            else if (mon_bi == 9) mon_stop = tx;
          end
        end
      end
      if (mon_aborted == 0) begin
        check("frame_byte", int'(mon_b), mon_exp);
        check("stop_bit", int'(mon_stop), 1);
        check("busy_len", mon_busy_len, FRAME);
        check("idle_after_stop", mon_end_idle, 1);
        mon_last_byte = int'(mon_b);
      end
    end
  end

  // Second instance: minimum stability, minimum bit time, heartbeat disabled.
  initial begin : d2_proc
    int c0, s2, blen, extra, bi;
    logic [7:0] b2;
    logic prev;
    wait (rst_released);
    repeat (20) @(posedge clk);
    #1;
    c0 = cyc;
    cmd2 = 5'b00100;
    s2 = -1;
    for (int k = 0; k < 10 && s2 < 0; k++) begin
      @(negedge clk);
      if (tx2 == 1'b0) s2 = cyc;
    end
    check("d2_latency", s2 - c0, 2);
    if (s2 >= 0) begin
      blen = int'(busy2);
      b2 = '0;
      for (int off = 1; off < 20; off++) begin
        @(negedge clk);
        blen += int'(busy2);
        if (off % 2 == 1) begin
          bi = off / 2;
          if (bi >= 1 && bi <= 8) b2[bi-1] = tx2;
        end
      end
      check("d2_byte", int'(b2), 'hA4);
      check("d2_busy_len", blen, 20);
    end
    extra = 0;
    prev = tx2;
    repeat (400) begin
      @(negedge clk);
      if (prev && !tx2) extra++;
      prev = tx2;
    end
    check("d2_no_heartbeat", extra, 0);
    d2_done = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    int c0, f0, js, found;
    logic [4:0] t;
    cmd = 5'($urandom);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    repeat (3) begin
      @(posedge clk);
      cmd = 5'($urandom);
    end
    #1;
    check("reset_hold_tx", int'(tx), 1);
    check("reset_hold_busy", int'(busy), 0);
    cmd = '0;
    resetn = 1'b1;
    model_reset();
    rst_released = 1'b1;

    repeat (150) step(5'b00000);
    check("idle_no_frame", frames_seen, 0);

    c0 = cyc;
    repeat (60) step(5'b00001);
    check("press_latency", mon_last_start - c0, 9);
    check("press_byte", mon_last_byte, 'hA1);

    f0 = frames_seen;
    repeat (5) step(5'b10001);
    repeat (30) step(5'b00001);
    check("glitch_no_frame", frames_seen - f0, 0);
    repeat (60) step(5'b10000);
    check("hold_action_byte", mon_last_byte, 'hB0);

    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      step(5'b01000);
      if (busy) found = 1;
    end
    check("change_busy_seen", found, 1);
    repeat (120) step(5'b11000);
    check("change_gap", mon_last_start - mon_prev_start, FRAME + 1);
    check("change_second_byte", mon_last_byte, 'hB8);

    f0 = frames_seen;
    repeat (700) step(5'b00100);
    check("heartbeat_count", frames_seen - f0, 4);
    check("heartbeat_period", mon_last_start - mon_prev_start, R);
    check("heartbeat_byte", mon_last_byte, 'hA4);

    repeat (40) begin
      t = 5'($urandom);
      repeat ($urandom_range(1, 16)) step(t);
    end

    for (int k = 0; k < 1000 && !d2_done; k++) step(cmd);
    check("d2_finished", int'(d2_done), 1);

    for (int k = 0; k < 100 && busy; k++) step(cmd);
    t = ~5'(m_last_sent);
    found = 0;
    js = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      step(t);
      if (busy) begin
        found = 1;
        js = cyc;
      end
    end
    check("midreset_frame_seen", found, 1);
    while (cyc < js + 17) step(t);
    check("midreset_busy_before", int'(busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_tx", int'(tx), 1);
    check("midreset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    c0 = cyc;
    repeat (60) step(5'b00010);
    check("midreset_latency", mon_last_start - c0, 9);
    check("midreset_byte", mon_last_byte, 'hA2);

    repeat (50) step(5'b00010);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
